// File: rtl/subneg_demux.sv
// Registered 1-to-2 demultiplexer with per-channel valid/ready holding registers.
// Optional per-channel delivery counters when SUBNEG_DEMUX_COUNT_EN is defined.
module subneg_demux #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             sel,
   output logic [WIDTH-1:0] out1_data,
   output logic             out1_valid,
   input  logic             out1_ready,
   output logic [WIDTH-1:0] out2_data,
   output logic             out2_valid,
   input  logic             out2_ready
`ifdef SUBNEG_DEMUX_COUNT_EN
   ,
   output logic [15:0]      out1_count,
   output logic [15:0]      out2_count
`endif
);

   typedef enum logic {EMPTY, FULL} chan_state_t;

   chan_state_t state1, state1_nxt;
   chan_state_t state2, state2_nxt;
   logic        room1, room2;
   logic        accept, acc1, acc2;
   logic        drain1, drain2;

   assign out1_valid = (state1 == FULL);
   assign out2_valid = (state2 == FULL);

   // Only the selected channel's room gates in_ready; the other may stall freely.
   assign room1    = !out1_valid || out1_ready;
   assign room2    = !out2_valid || out2_ready;
   assign in_ready = sel ? room2 : room1;

   assign accept = in_valid && in_ready;
   assign acc1   = accept && !sel;
   assign acc2   = accept && sel;
   assign drain1 = out1_valid && out1_ready;
   assign drain2 = out2_valid && out2_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state1 <= EMPTY;
         state2 <= EMPTY;
      end else begin
         state1 <= state1_nxt;
         state2 <= state2_nxt;
      end
   end

   always_comb begin
      state1_nxt = state1;
      state2_nxt = state2;
      if (acc1)
         state1_nxt = FULL;
      else if (drain1)
         state1_nxt = EMPTY;
      if (acc2)
         state2_nxt = FULL;
      else if (drain2)
         state2_nxt = EMPTY;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out1_data <= '0;
         out2_data <= '0;
      end else begin
         if (acc1)
            out1_data <= in_data;
         if (acc2)
            out2_data <= in_data;
      end
   end

`ifdef SUBNEG_DEMUX_COUNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out1_count <= '0;
         out2_count <= '0;
      end else begin
         if (drain1)
            out1_count <= out1_count + 16'd1;
         if (drain2)
            out2_count <= out2_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_subneg_demux.sv
// Self-checking bench for subneg_demux: queue-based channel model plus directed
// literal checks; counter checks compile in with SUBNEG_DEMUX_COUNT_EN.
module tb_subneg_demux;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [W-1:0] in_data;
   logic         in_valid;
   logic         in_ready;
   logic         sel;
   logic [W-1:0] out1_data, out2_data;
   logic         out1_valid, out2_valid;
   logic         out1_ready, out2_ready;
`ifdef SUBNEG_DEMUX_COUNT_EN
   logic [15:0]  out1_count, out2_count;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   subneg_demux #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .sel        (sel),
      .out1_data  (out1_data),
      .out1_valid (out1_valid),
      .out1_ready (out1_ready),
      .out2_data  (out2_data),
      .out2_valid (out2_valid),
      .out2_ready (out2_ready)
`ifdef SUBNEG_DEMUX_COUNT_EN
      ,
      .out1_count (out1_count),
      .out2_count (out2_count)
`endif
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Model: each channel is a queue holding at most one word.
   logic [W-1:0] q1[$], q2[$];
   logic [W-1:0] sent1[$], sent2[$], rx1[$], rx2[$];
   int unsigned  c1 = 0, c2 = 0;
   bit           m_acc = 0;
   bit           r1, r2, acc;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q1.delete();
         q2.delete();
         c1 = 0;
         c2 = 0;
         m_acc = 0;
      end else begin
         r1  = (q1.size() == 0) || out1_ready;
         r2  = (q2.size() == 0) || out2_ready;
         acc = in_valid && (sel ? r2 : r1);
         if (q1.size() > 0 && out1_ready) begin
            void'(q1.pop_front());
            c1 = (c1 + 1) % 65536;
         end
         if (q2.size() > 0 && out2_ready) begin
            void'(q2.pop_front());
            c2 = (c2 + 1) % 65536;
         end
         if (acc) begin
            if (sel) begin
               q2.push_back(in_data);
               sent2.push_back(in_data);
            end else begin
               q1.push_back(in_data);
               sent1.push_back(in_data);
            end
         end
         m_acc = acc;
      end
   end

   // Compare process: every falling edge, DUT against the model.
   always @(negedge clk) begin
      chk("out1_valid", out1_valid, q1.size() > 0);
      chk("out2_valid", out2_valid, q2.size() > 0);
      if (q1.size() > 0) chk("out1_data", out1_data, q1[0]);
      if (q2.size() > 0) chk("out2_data", out2_data, q2[0]);
      chk("in_ready", in_ready,
          sel ? ((q2.size() == 0) || out2_ready) : ((q1.size() == 0) || out1_ready));
`ifdef SUBNEG_DEMUX_COUNT_EN
      chk("out1_count", out1_count, c1);
      chk("out2_count", out2_count, c2);
`endif
      if (rst_n && out1_valid && out1_ready) rx1.push_back(out1_data);
      if (rst_n && out2_valid && out2_ready) rx2.push_back(out2_data);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int sent;
      int budget;
      logic [W-1:0] cur_d;
      logic         cur_s;

      rst_n = 1'b0;
      in_data = '0; in_valid = 1'b0; sel = 1'b0;
      out1_ready = 1'b0; out2_ready = 1'b0;
      repeat (3) step();
      rst_n = 1'b1;
      #1;
      // Reset state
      chk("rst_out1_valid", out1_valid, 0);
      chk("rst_out2_valid", out2_valid, 0);
      chk("rst_out1_data", out1_data, 8'h00);
      chk("rst_out2_data", out2_data, 8'h00);
      chk("rst_in_ready", in_ready, 1);
      step();

      // Single route
      in_data = 8'hA5; sel = 1'b0; in_valid = 1'b1; out1_ready = 1'b1;
      step();
      in_valid = 1'b0;
      chk("single_v1", out1_valid, 1);
      chk("single_d1", out1_data, 8'hA5);
      chk("single_v2", out2_valid, 0);
      step();
      chk("single_v1_drained", out1_valid, 0);
      out1_ready = 1'b0;

      // Back-pressure on channel 2
      sel = 1'b1; out2_ready = 1'b0; in_data = 8'h11; in_valid = 1'b1;
      step();
      in_data = 8'h22;
      #1;
      chk("bp_in_ready", in_ready, 0);
      chk("bp_d2_first", out2_data, 8'h11);
      step();
      chk("bp_d2_held", out2_data, 8'h11);
      chk("bp_v2_held", out2_valid, 1);
      out2_ready = 1'b1;
      #1;
      chk("bp_in_ready_open", in_ready, 1);
      step();
      in_valid = 1'b0;
      chk("bp_d2_second", out2_data, 8'h22);
      chk("bp_v2_second", out2_valid, 1);
      step();
      chk("bp_v2_drained", out2_valid, 0);
      out2_ready = 1'b0;

      // Independence: channel 1 stalled full, channel 2 still accepts
      sel = 1'b0; in_data = 8'h77; in_valid = 1'b1;
      step();
      sel = 1'b1; in_data = 8'h3C;
      #1;
      chk("ind_in_ready", in_ready, 1);
      step();
      in_valid = 1'b0;
      chk("ind_d2", out2_data, 8'h3C);
      chk("ind_d1", out1_data, 8'h77);
      chk("ind_v1", out1_valid, 1);
      out1_ready = 1'b1; out2_ready = 1'b1;
      repeat (2) step();

      // Streaming: 100 random words, random sel, 50% ready per channel
      sent = 0;
      budget = 0;
      cur_d = W'($urandom);
      cur_s = 1'($urandom);
      while (sent < 100 && budget < 3000) begin
         in_valid = 1'b1; in_data = cur_d; sel = cur_s;
         out1_ready = 1'($urandom_range(0, 1));
         out2_ready = 1'($urandom_range(0, 1));
         step();
         budget++;
         if (m_acc) begin
            sent++;
            cur_d = W'($urandom);
            cur_s = 1'($urandom);
         end
      end
      chk("stream_budget", sent, 100);
      in_valid = 1'b0; out1_ready = 1'b1; out2_ready = 1'b1;
      repeat (3) step();
      chk("stream_cnt1", rx1.size(), sent1.size());
      chk("stream_cnt2", rx2.size(), sent2.size());
      chk("stream_total", sent1.size() + sent2.size(), 100 + 5);
      for (int i = 0; i < sent1.size() && i < rx1.size(); i++)
         chk("stream_ord1", rx1[i], sent1[i]);
      for (int i = 0; i < sent2.size() && i < rx2.size(); i++)
         chk("stream_ord2", rx2[i], sent2[i]);
      sent1.delete(); sent2.delete(); rx1.delete(); rx2.delete();

      // Async reset mid-stream with both channels full
      out1_ready = 1'b0; out2_ready = 1'b0;
      in_valid = 1'b1; sel = 1'b0; in_data = 8'h5A;
      step();
      sel = 1'b1; in_data = 8'hC3;
      step();
      in_valid = 1'b0;
      chk("ar_full1", out1_valid, 1);
      chk("ar_full2", out2_valid, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_v1", out1_valid, 0);
      chk("ar_v2", out2_valid, 0);
      chk("ar_d1", out1_data, 8'h00);
      chk("ar_d2", out2_data, 8'h00);
      step();
      rst_n = 1'b1;
      #1;
      chk("ar_in_ready", in_ready, 1);
      step();

`ifdef SUBNEG_DEMUX_COUNT_EN
      // Counter wrap after 65536 channel 1 transfers
      out1_ready = 1'b1; sel = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 65536; i++) begin
         in_data = W'(i);
         step();
      end
      in_valid = 1'b0;
      step();
      chk("cnt1_wrap", out1_count, 16'h0000);
      chk("cnt2_idle", out2_count, 16'h0000);
      sent1.delete(); rx1.delete();
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
